in_order_collector: RTL and testbench

IN_ORDER_COLLECTOR -- requirements
Module: in_order_collector

---
 rtl/in_order_pkg.sv | 13 +
 rtl/in_order_collector_slot.sv | 49 ++++
 rtl/in_order_collector.sv | 101 ++++++++++
 tb/tb_in_order_collector.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/in_order_pkg.sv
// Shared defaults and pointer-width helper for the in-order result collector.
package in_order_pkg;

  localparam int unsigned DefWidth   = 16;
  localparam int unsigned DefNInputs = 5;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefPtrW = ptr_width(DefNInputs);

endpackage

// File: rtl/in_order_collector_slot.sv
// Single-entry result slot: capture on write when empty or draining, flag writes that collide.
module order_slot
  import in_order_pkg::*;
#(
  parameter int unsigned width = DefWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [width-1:0] i_wr_data,
  input  logic             i_drain,
  output logic             o_vld,
  output logic [width-1:0] o_data,
  output logic             o_free,
  output logic             o_ovf
);

  logic             r_vld;
  logic             r_free;
  logic [width-1:0] r_data;
  logic             w_capture;
  logic             w_vld_d;

  // A drain on the same edge frees the entry, so the incoming word may take its place.
  assign w_capture = i_wr && (!r_vld || i_drain);
  assign w_vld_d   = w_capture || (r_vld && !i_drain);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld  <= 1'b0;
      r_free <= 1'b1;
    end else begin
      r_vld  <= w_vld_d;
      r_free <= !w_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_data <= i_wr_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_free = r_free;
  assign o_ovf  = i_wr && r_vld && !i_drain;

endmodule

// File: rtl/in_order_collector.sv
// Reorders results from round-robin dispatched variable-latency units back into dispatch order.
module in_order_collector
  import in_order_pkg::*;
#(
  parameter int unsigned width    = DefWidth,
  parameter int unsigned n_inputs = DefNInputs
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_inputs-1:0]       up_vld,
  input  logic [n_inputs*width-1:0] up_data,
  output logic [n_inputs-1:0]       slot_free,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [width-1:0]          out_data,
  output logic                      overflow
);

  localparam int unsigned PtrW = ptr_width(n_inputs);

  logic [n_inputs-1:0] w_slot_vld;
  logic [n_inputs-1:0] w_slot_free;
  logic [n_inputs-1:0] w_drain;
  logic [n_inputs-1:0] w_ovf;
  logic [width-1:0]    w_slot_data [n_inputs];

  logic                w_head_vld;
  logic [width-1:0]    w_head_data;
  logic                w_load;
  logic [PtrW-1:0]     w_rd_ptr_nxt;

  logic [PtrW-1:0]     r_rd_ptr;
  logic                r_out_vld;
  logic [width-1:0]    r_out_data;
  logic                r_overflow;

  for (genvar g = 0; g < n_inputs; g++) begin : g_slot
    order_slot #(
      .width(width)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_wr     (up_vld[g]),
      .i_wr_data(up_data[g*width +: width]),
      .i_drain  (w_drain[g]),
      .o_vld    (w_slot_vld[g]),
      .o_data   (w_slot_data[g]),
      .o_free   (w_slot_free[g]),
      .o_ovf    (w_ovf[g])
    );
  end

  always_comb begin
    w_head_vld  = 1'b0;
    w_head_data = '0;
    for (int i = 0; i < n_inputs; i++) begin
      if (r_rd_ptr == PtrW'(i)) begin
        w_head_vld  = w_slot_vld[i];
        w_head_data = w_slot_data[i];
      end
    end
  end

  assign w_load = (!r_out_vld || out_rdy) && w_head_vld;

  always_comb begin
    w_drain = '0;
    for (int i = 0; i < n_inputs; i++) begin
      w_drain[i] = w_load && (r_rd_ptr == PtrW'(i));
    end
  end

  // Explicit wrap since n_inputs need not be a power of two.
  assign w_rd_ptr_nxt = (r_rd_ptr == PtrW'(n_inputs - 1)) ? '0 : r_rd_ptr + PtrW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data <= w_head_data;
        r_out_vld  <= 1'b1;
        r_rd_ptr   <= w_rd_ptr_nxt;
      end else if (out_rdy) begin
        r_out_vld <= 1'b0;
      end
      if (|w_ovf) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign slot_free = w_slot_free;
  assign out_vld   = r_out_vld;
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_in_order_collector.sv
// Bench for in_order_collector: vector table plus multi-cycle sequences, scoreboard on output.
module tb_in_order_collector;

  localparam int W = 16;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   up_vld = '0;
  logic [N*W-1:0] up_data = '0;
  logic [N-1:0]   slot_free;
  logic           out_vld;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   out_data;
  logic           overflow;

  always #5 clk = ~clk;

  in_order_collector #(
    .width   (W),
    .n_inputs(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .up_vld   (up_vld),
    .up_data  (up_data),
    .slot_free(slot_free),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .overflow (overflow)
  );

  typedef struct {
    logic         rst_n;
    logic [N-1:0] vld;
    logic [W-1:0] data;
    logic         rdy;
    logic         exp_ovld;
    logic [W-1:0] exp_odata;
    logic [N-1:0] exp_free;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    int           unit;
    logic [W-1:0] data;
  } sb_t;

  vec_t vecs [13];
  sb_t  sb_q [$];
  int   mon_ptr = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every accepted output must be the oldest pending word of the unit the order says is next.
  always @(negedge clk) begin
    int idx;
    if (rst && out_vld && out_rdy) begin
      idx = -1;
      for (int k = 0; k < sb_q.size(); k++) begin
        if (idx < 0 && sb_q[k].unit == mon_ptr) idx = k;
      end
      n_out++;
      if (idx < 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected no word for unit %0d", out_data, mon_ptr);
      end else begin
        chk($sformatf("sb_order_unit%0d", mon_ptr), 32'(out_data), 32'(sb_q[idx].data));
        sb_q.delete(idx);
      end
      mon_ptr = (mon_ptr == N - 1) ? 0 : mon_ptr + 1;
    end
  end

  task automatic flush_sb();
    sb_q.delete();
    mon_ptr = 0;
  endtask

  task automatic cyc(input logic [N-1:0] vld, input logic [N*W-1:0] dat, input bit push);
    up_vld  = vld;
    up_data = dat;
    if (push) begin
      for (int i = 0; i < N; i++) begin
        if (vld[i]) sb_q.push_back('{unit: i, data: dat[i*W +: W]});
      end
    end
    @(posedge clk);
    #1;
    up_vld = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_sb();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int out0;
    logic [W-1:0] exp32 [5];

    vecs[0]  = '{1'b1, 5'b00001, 16'h1111, 1'b1, 1'b0, 16'h0000, 5'b11110, 1'b0};
    vecs[1]  = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b1, 16'h1111, 5'b11111, 1'b0};
    vecs[2]  = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b0, 16'h1111, 5'b11111, 1'b0};
    vecs[3]  = '{1'b1, 5'b00110, 16'h2222, 1'b1, 1'b0, 16'h1111, 5'b11001, 1'b0};
    vecs[4]  = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b1, 16'h2222, 5'b11011, 1'b0};
    vecs[5]  = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b1, 16'h2222, 5'b11111, 1'b0};
    vecs[6]  = '{1'b0, 5'b00000, 16'h0000, 1'b1, 1'b0, 16'h0000, 5'b11111, 1'b0};
    vecs[7]  = '{1'b1, 5'b00100, 16'h000C, 1'b1, 1'b0, 16'h0000, 5'b11011, 1'b0};
    vecs[8]  = '{1'b1, 5'b00001, 16'h000A, 1'b1, 1'b0, 16'h0000, 5'b11010, 1'b0};
    vecs[9]  = '{1'b1, 5'b00010, 16'h000B, 1'b1, 1'b1, 16'h000A, 5'b11001, 1'b0};
    vecs[10] = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b1, 16'h000B, 5'b11011, 1'b0};
    vecs[11] = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b1, 16'h000C, 5'b11111, 1'b0};
    vecs[12] = '{1'b1, 5'b00000, 16'h0000, 1'b1, 1'b0, 16'h000C, 5'b11111, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_slot_free", 32'(slot_free), 32'h1F);
    rst = 1'b1;

    for (int k = 0; k < 13; k++) begin
      rst = vecs[k].rst_n;
      if (!vecs[k].rst_n) flush_sb();
      out_rdy = vecs[k].rdy;
      cyc(vecs[k].vld, {N{vecs[k].data}}, 1'b1);
      chk($sformatf("vec%0d_out_vld", k), 32'(out_vld), 32'(vecs[k].exp_ovld));
      chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(vecs[k].exp_odata));
      chk($sformatf("vec%0d_slot_free", k), 32'(slot_free), 32'(vecs[k].exp_free));
      chk($sformatf("vec%0d_overflow", k), 32'(overflow), 32'(vecs[k].exp_ovf));
    end
    rst = 1'b1;

    // Full fill, stalled output, back-to-back drain and pointer wrap.
    do_reset();
    out_rdy = 1'b0;
    cyc(5'b11111, {16'h0014, 16'h0013, 16'h0012, 16'h0011, 16'h0010}, 1'b1);
    chk("fill_out_vld_latency", 32'(out_vld), 32'd0);
    cyc('0, '0, 1'b0);
    chk("fill_first_data", 32'(out_data), 32'h10);
    chk("fill_slot_free", 32'(slot_free), 32'h01);
    for (int j = 0; j < 4; j++) begin
      cyc('0, '0, 1'b0);
      chk($sformatf("stall%0d_out_vld", j), 32'(out_vld), 32'd1);
      chk($sformatf("stall%0d_out_data", j), 32'(out_data), 32'h10);
    end
    exp32[0] = 16'h11; exp32[1] = 16'h12; exp32[2] = 16'h13;
    exp32[3] = 16'h14; exp32[4] = 16'h20;
    out_rdy = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 0) cyc(5'b00001, {{(N-1)*W{1'b0}}, 16'h0020}, 1'b1);
      else        cyc('0, '0, 1'b0);
      chk($sformatf("drain%0d_out_vld", j), 32'(out_vld), 32'd1);
      chk($sformatf("drain%0d_out_data", j), 32'(out_data), 32'(exp32[j]));
    end
    cyc('0, '0, 1'b0);
    chk("drain_end_out_vld", 32'(out_vld), 32'd0);
    chk("drain_end_slot_free", 32'(slot_free), 32'h1F);
    chk("drain_end_sb_empty", 32'(sb_q.size()), 32'd0);

    // Collision on a non-head slot: sticky overflow, original word kept.
    do_reset();
    out_rdy = 1'b1;
    out0 = n_out;
    cyc(5'b01000, {16'h0000, 16'h00D3, 16'h0000, 16'h0000, 16'h0000}, 1'b1);
    chk("ovf_before", 32'(overflow), 32'd0);
    cyc(5'b01000, {16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000}, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (2) cyc('0, '0, 1'b0);
    chk("ovf_sticky_idle", 32'(overflow), 32'd1);
    cyc(5'b00111, {16'h0000, 16'h0000, 16'h00A2, 16'h00A1, 16'h00A0}, 1'b1);
    repeat (6) cyc('0, '0, 1'b0);
    chk("ovf_sticky_end", 32'(overflow), 32'd1);
    chk("ovf_out_count", 32'(n_out - out0), 32'd4);
    chk("ovf_sb_empty", 32'(sb_q.size()), 32'd0);

    // Drain and arrival on the head slot at the same edge.
    do_reset();
    out_rdy = 1'b1;
    out0 = n_out;
    cyc(5'b11111, {16'h0034, 16'h0033, 16'h0032, 16'h0031, 16'h0030}, 1'b1);
    cyc(5'b00001, {{(N-1)*W{1'b0}}, 16'h0055}, 1'b1);
    chk("same_edge_out_data", 32'(out_data), 32'h30);
    chk("same_edge_slot_free", 32'(slot_free), 32'h00);
    chk("same_edge_overflow", 32'(overflow), 32'd0);
    repeat (7) cyc('0, '0, 1'b0);
    chk("same_edge_ovf_end", 32'(overflow), 32'd0);
    chk("same_edge_out_count", 32'(n_out - out0), 32'd6);
    chk("same_edge_sb_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset between edges while holding output and buffered words.
    do_reset();
    out_rdy = 1'b0;
    cyc(5'b01111, {16'h0000, 16'h0043, 16'h0042, 16'h0041, 16'h0040}, 1'b1);
    cyc('0, '0, 1'b0);
    chk("arst_pre_out_vld", 32'(out_vld), 32'd1);
    #2;
    rst = 1'b0;
    flush_sb();
    #1;
    chk("arst_out_vld", 32'(out_vld), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    chk("arst_slot_free", 32'(slot_free), 32'h1F);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    cyc(5'b00011, {16'h0000, 16'h0000, 16'h0000, 16'h0061, 16'h0060}, 1'b1);
    cyc('0, '0, 1'b0);
    chk("arst_first_vld", 32'(out_vld), 32'd1);
    chk("arst_first_data", 32'(out_data), 32'h60);
    cyc('0, '0, 1'b0);
    chk("arst_second_data", 32'(out_data), 32'h61);
    repeat (2) cyc('0, '0, 1'b0);
    chk("arst_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
